mem_stage: RTL

- Memory stage of the 16-bit single-issue datapath, directly downstream of execute.
- Accepts the execute result (ALU result / effective address) plus store data and memory-control flags.
- Drives a variable-latency data-memory request/done handshake and stalls upstream while an access is outstanding.
- Registers a write-back value and a per-instruction retire pulse for the write-back stage.

---
 rtl/mem_stage_pkg.sv | 12 +
 rtl/mem_stage_if.sv | 16 +
 rtl/mem_timeout_ctr.sv | 27 ++
 rtl/mem_stage.sv | 111 +++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory stage: FSM state encoding, word width, default timeout.
package mem_stage_pkg;
    localparam int WORD_W      = 16;
    localparam int TIMEOUT_DEF = 64;

    typedef logic [WORD_W-1:0] word_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_ERR    = 2'd3;
endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/done handshake between the memory stage (master) and data memory (slave).
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic  mem_req;
    logic  mem_wr;
    word_t mem_addr;
    word_t mem_wdata;
    logic  mem_done;
    word_t mem_rdata;

    modport master (output mem_req, mem_wr, mem_addr, mem_wdata,
                    input  mem_done, mem_rdata);
    modport slave  (input  mem_req, mem_wr, mem_addr, mem_wdata,
                    output mem_done, mem_rdata);
endinterface

// File: rtl/mem_timeout_ctr.sv
// 8-bit saturating wait counter; o_expired flags the last permitted BUSY cycle (count == TIMEOUT-1).
module mem_timeout_ctr
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
)(
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= 8'd0;
        else if (i_clr)
            r_cnt <= 8'd0;
        else if (i_en && r_cnt != 8'hFF)
            r_cnt <= r_cnt + 8'd1;
    end

    assign o_expired = (r_cnt == LIMIT);
endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues one data-memory access per load/store, stalls upstream while busy, retires to WB.
// Optional build macro MEM_ALIGN_CHECK_EN traps odd-address loads/stores as errors.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_valid,
    input  word_t      ex_result,
    input  word_t      ex_wdata,
    input  logic       mem_read,
    input  logic       mem_write,
    input  logic       halt,
    output logic       stall,
    mem_stage_if.master mem,
    output logic       wb_valid,
    output word_t      wb_data,
    output logic       halted,
    output logic       err
);
    logic [1:0] r_state;
    logic       r_req, r_wr, r_is_load, r_wb_valid, r_halted, r_err;
    word_t      r_addr, r_wdata, r_wb_data;

    logic w_accept, w_is_mem, w_illegal, w_unaligned, w_busy_wait, w_expired;

    assign w_accept    = (r_state == ST_IDLE) && ex_valid;
    assign w_is_mem    = mem_read ^ mem_write;
    assign w_illegal   = mem_read & mem_write;
    assign w_busy_wait = (r_state == ST_BUSY) && !mem.mem_done;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_unaligned = ex_result[0];
`else
    assign w_unaligned = 1'b0;
`endif

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_accept),
        .i_en      (w_busy_wait),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_wr       <= 1'b0;
            r_is_load  <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_halted   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_req      <= 1'b0;
            r_wb_valid <= 1'b0;
            case (r_state)
                ST_IDLE: if (ex_valid) begin
                    // halt outranks the memory flags; bad ops trap before any request goes out
                    if (halt) begin
                        r_wb_valid <= 1'b1;
                        r_wb_data  <= ex_result;
                        r_halted   <= 1'b1;
                        r_state    <= ST_HALTED;
                    end else if (w_illegal || (w_is_mem && w_unaligned)) begin
                        r_err   <= 1'b1;
                        r_state <= ST_ERR;
                    end else if (w_is_mem) begin
                        r_req     <= 1'b1;
                        r_wr      <= mem_write;
                        r_is_load <= mem_read;
                        r_addr    <= ex_result;
                        r_wdata   <= ex_wdata;
                        r_state   <= ST_BUSY;
                    end else begin
                        r_wb_valid <= 1'b1;
                        r_wb_data  <= ex_result;
                    end
                end
                ST_BUSY: begin
                    // a done arriving in the expiry cycle still completes normally
                    if (mem.mem_done) begin
                        r_wb_valid <= 1'b1;
                        r_wb_data  <= r_is_load ? mem.mem_rdata : r_addr;
                        r_state    <= ST_IDLE;
                    end else if (w_expired) begin
                        r_err   <= 1'b1;
                        r_state <= ST_ERR;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall         = (r_state != ST_IDLE);
    assign mem.mem_req   = r_req;
    assign mem.mem_wr    = r_wr;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;
    assign wb_valid      = r_wb_valid;
    assign wb_data       = r_wb_data;
    assign halted        = r_halted;
    assign err           = r_err;
endmodule
